// File: rtl/dummy_completion_monitor.sv
// Completion checker for dummy IP instances: armed with a source mask, collects
// done pulses and reports a sticky pass, or a fail on timeout.
module dummy_completion_monitor #(
  parameter int NumSources    = 4,
  parameter int TimeoutCycles = 1000,
  parameter int CntWidth      = $clog2(TimeoutCycles + 1),
  parameter int IdxWidth      = (NumSources > 1) ? $clog2(NumSources) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_valid_i,
  output logic                  arm_ready_o,
  input  logic [NumSources-1:0] arm_mask_i,
  input  logic [NumSources-1:0] done_i,
  input  logic                  clear_i,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [NumSources-1:0] pending_o,
  output logic                  missing_valid_o,
  output logic [IdxWidth-1:0]   first_missing_o,
  output logic [CntWidth-1:0]   elapsed_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [NumSources-1:0] r_pending;
  logic [NumSources-1:0] w_pending_next;
  logic [NumSources-1:0] w_pending_done;
  logic [CntWidth-1:0]   r_cnt;
  logic [CntWidth-1:0]   w_cnt_next;
  logic [IdxWidth-1:0]   w_first_missing;

  assign w_pending_done = r_pending & ~done_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_cnt     <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_cnt_next     = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (arm_valid_i) begin
          w_pending_next = arm_mask_i;
          w_cnt_next     = '0;
          w_state_next   = (arm_mask_i == '0) ? S_PASS : S_ARMED;
        end
      end
      S_ARMED: begin
        w_pending_next = w_pending_done;
        w_cnt_next     = r_cnt + CntWidth'(1);
        // Completion wins over a timeout landing in the same cycle.
        if (w_pending_done == '0) begin
          w_state_next = S_PASS;
        end else if (r_cnt == LastCnt) begin
          w_state_next = S_FAIL;
        end
      end
      S_PASS, S_FAIL: begin
        if (clear_i) begin
          w_state_next   = S_IDLE;
          w_pending_next = '0;
          w_cnt_next     = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Scan downward so the lowest set bit is the one left standing.
  always_comb begin
    w_first_missing = '0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_first_missing = IdxWidth'(i);
      end
    end
  end

  assign arm_ready_o     = (r_state == S_IDLE);
  assign pass_o          = (r_state == S_PASS);
  assign fail_o          = (r_state == S_FAIL);
  assign pending_o       = r_pending;
  assign missing_valid_o = |r_pending;
  assign first_missing_o = w_first_missing;
  assign elapsed_o       = r_cnt;

endmodule

// File: tb/tb_dummy_completion_monitor.sv
// Directed bench for dummy_completion_monitor: a vector table for the basic flow
// plus hand-written windows for timeout, boundary completion and reset.
module tb_dummy_completion_monitor;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int CW = $clog2(T + 1);
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm_valid;
  logic          arm_ready;
  logic [N-1:0]  arm_mask;
  logic [N-1:0]  done;
  logic          clear;
  logic          pass_w;
  logic          fail_w;
  logic [N-1:0]  pending;
  logic          missing_valid;
  logic [IW-1:0] first_missing;
  logic [CW-1:0] elapsed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dummy_completion_monitor #(
    .NumSources   (N),
    .TimeoutCycles(T)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .arm_valid_i    (arm_valid),
    .arm_ready_o    (arm_ready),
    .arm_mask_i     (arm_mask),
    .done_i         (done),
    .clear_i        (clear),
    .pass_o         (pass_w),
    .fail_o         (fail_w),
    .pending_o      (pending),
    .missing_valid_o(missing_valid),
    .first_missing_o(first_missing),
    .elapsed_o      (elapsed)
  );

  typedef struct {
    logic          rst;
    logic          arm_valid;
    logic [N-1:0]  mask;
    logic [N-1:0]  done;
    logic          clear;
    logic          e_ready;
    logic          e_pass;
    logic          e_fail;
    logic [N-1:0]  e_pending;
    logic [IW-1:0] e_first;
    logic [CW-1:0] e_elapsed;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; arm_valid = 1'b0; arm_mask = '0; done = '0; clear = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic e_ready, input logic e_pass,
                           input logic e_fail, input logic [N-1:0] e_pend,
                           input logic [IW-1:0] e_first, input logic [CW-1:0] e_el);
    check({tag, ".ready"},   32'(arm_ready),     32'(e_ready));
    check({tag, ".pass"},    32'(pass_w),        32'(e_pass));
    check({tag, ".fail"},    32'(fail_w),        32'(e_fail));
    check({tag, ".pending"}, 32'(pending),       32'(e_pend));
    check({tag, ".mvalid"},  32'(missing_valid), 32'(e_pend != '0));
    check({tag, ".first"},   32'(first_missing), 32'(e_first));
    check({tag, ".elapsed"}, 32'(elapsed),       32'(e_el));
  endtask

  // Arm in cycle 0, drive dpat in cycles dfrom..dto (up to 20), verdict due in cycle T+1.
  task automatic window(input string tag, input logic [N-1:0] mask, input logic [N-1:0] dpat,
                        input int dfrom, input int dto, input logic e_pass,
                        input logic [N-1:0] e_pend, input logic [IW-1:0] e_first);
    idle_inputs();
    arm_valid = 1'b1; arm_mask = mask;
    step();
    idle_inputs();
    for (int c = 1; c <= 20; c++) begin
      done = (c >= dfrom && c <= dto) ? dpat : '0;
      step();
      if (c < T) begin
        check({tag, ".early_verdict"}, 32'({pass_w, fail_w}), 32'(0));
      end else if (c == T) begin
        check_all({tag, ".verdict"}, 1'b0, e_pass, !e_pass, e_pend, e_first, CW'(T));
      end else begin
        check({tag, ".sticky"}, 32'({pass_w, fail_w}), 32'({e_pass, !e_pass}));
      end
    end
    idle_inputs();
    clear = 1'b1;
    step();
    idle_inputs();
    check_all({tag, ".cleared"}, 1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();

    //              rst  av  mask     done     clr  rdy  pass fail pend     first el
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 5'd0};
    vecs[1]  = '{1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'd0, 5'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 2'd0, 5'd1};
    vecs[3]  = '{1'b0, 1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'd0, 5'd2};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 5'd3};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 5'd4};
    vecs[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 5'd5};
    vecs[7]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 5'd5};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 5'd0};
    vecs[9]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 5'd0};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 5'd0};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 5'd0};

    for (int i = 0; i < 12; i++) begin
      rst       = vecs[i].rst;
      arm_valid = vecs[i].arm_valid;
      arm_mask  = vecs[i].mask;
      done      = vecs[i].done;
      clear     = vecs[i].clear;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_pass, vecs[i].e_fail,
                vecs[i].e_pending, vecs[i].e_first, vecs[i].e_elapsed);
      $display("[TB] vec %0d applied: pass=%0b fail=%0b pending=%b elapsed=%0d",
               i, pass_w, fail_w, pending, elapsed);
    end
    idle_inputs();

    window("timeout",    4'b1111, 4'b1011, 2, 2,  1'b0, 4'b0100, 2'd2);
    $display("[TB] timeout window done");
    window("boundary",   4'b0001, 4'b0001, 16, 16, 1'b1, 4'b0000, 2'd0);
    $display("[TB] boundary window done");
    window("out_of_mask", 4'b0010, 4'b1101, 1, 20, 1'b0, 4'b0010, 2'd1);
    $display("[TB] out-of-mask window done");

    // Reset in ARMED cycle 5 together with a completing done.
    idle_inputs();
    arm_valid = 1'b1; arm_mask = 4'b1111;
    step();
    idle_inputs();
    for (int c = 1; c < 5; c++) step();
    check("rst_mid.pre_elapsed", 32'(elapsed), 32'(4));
    rst = 1'b1; done = 4'b1111;
    step();
    idle_inputs();
    check_all("rst_mid.after", 1'b1, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 20; c++) begin
      step();
      check("rst_mid.quiet", 32'({pass_w, fail_w, arm_ready}), 32'(3'b001));
    end
    $display("[TB] reset-mid sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
